pe_loader_tx: RTL
=================

PE_LOADER_TX -- requirements
Module: pe_loader_tx

Interface
REQ-001 SHALL have parameter PACKET_WIDTH, default 64, total packet width.
REQ-002 SHALL have parameter FILTER_LENGTH, default 40, filter-row payload bits.
REQ-003 SHALL have parameter IFMAP_LENGTH, default 25, ifmap-row payload bits.
REQ-004 SHALL have parameter NUM_IFMAP_ROWS, default 25, ifmap rows per layer.
REQ-005 SHALL have parameter SRC_ADDR, default 4'b0000, source node address.
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port start, input, 1, single-cycle request to begin one layer load.
REQ-009 SHALL have ports filter_data, input, FILTER_LENGTH, and filter_valid, input, 1, carrying a filter row; plus filter_ready, output, 1, its acceptance.
REQ-010 SHALL have ports ifmap_data, input, IFMAP_LENGTH, and ifmap_valid, input, 1, carrying an ifmap row; plus ifmap_ready, output, 1, its acceptance.
REQ-011 SHALL have ports pkt_out, output, PACKET_WIDTH, packet to the NoC; pkt_valid, output, 1, packet present; and pkt_ready, input, 1, NoC acceptance.
REQ-012 SHALL have ports busy, output, 1, high from start accept until done; and done, output, 1, single-cycle completion pulse.

Function
REQ-013 Packet format SHALL be: [63:60] destination; [59:56] SRC_ADDR; [55:54] type; [53:0] payload, zero-extended from bit 0.
REQ-014 Type SHALL be 2'b01 for filter packets and 2'b00 for ifmap packets; 2'b10 and 2'b11 SHALL never be emitted.
REQ-015 PE addresses SHALL be PE1=0001, PE2=0101, PE3=0011, PE4=0111, PE5=1100.
REQ-016 The FSM SHALL have states IDLE, FILTER, IFMAP, DONE.
REQ-017 IDLE->FILTER SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-018 In FILTER, five filter rows SHALL be accepted in order: row k goes to PE(k+1), k=0..4; after the fifth accept the FSM SHALL move to IFMAP.
REQ-019 In IFMAP, NUM_IFMAP_ROWS rows SHALL be accepted: row r<5 goes to PE(r+1); row r>=5 goes to PE5.
REQ-020 After the last ifmap accept the FSM SHALL enter DONE.
REQ-021 DONE SHALL return to IDLE only after the last packet handshake, pulsing done for exactly that one cycle.
REQ-022 A filter or ifmap handshake SHALL occur only when the FSM is in the matching state and the output slot is free (pkt_valid=0 or pkt_ready=1).
REQ-023 filter_ready and ifmap_ready SHALL never both be 1.
REQ-024 An accepted row SHALL appear on pkt_out with pkt_valid=1 in the next cycle (latency 1).
REQ-025 Sustained throughput SHALL be one packet per cycle while pkt_ready=1.
REQ-026 While pkt_valid=1 and pkt_ready=0, pkt_out SHALL hold stable and no new row SHALL be accepted.
REQ-027 pkt_valid SHALL deassert after a handshake unless a new row is accepted in the same cycle.
REQ-028 Input valid seen in a non-matching state SHALL be ignored; data SHALL not be consumed.
REQ-029 The row counter SHALL count 0..NUM_IFMAP_ROWS-1 with width $clog2(NUM_IFMAP_ROWS+1) and SHALL clear on entry to FILTER.

Reset
REQ-030 When rst asserts, with no clock, the FSM SHALL enter IDLE and the counters SHALL clear.
REQ-031 On reset, pkt_valid, filter_ready, ifmap_ready, busy and done SHALL be 0, and pkt_out SHALL be 0.
REQ-032 Reset mid-load SHALL discard the pending packet; the next start SHALL restart from filter row 0.

Structure
REQ-033 Package pe_noc_pkg SHALL hold the PE address constants, the type codes (IFMAP=00, FILTER=01, PSUM=10) and the field-position constants, shared with the PE packetizer and depacketizer.
REQ-034 The one-entry output register with valid/ready logic SHALL be the sub-module pkt_out_slot; FSM and counters SHALL stay in pe_loader_tx.

Verification
REQ-035 Stimulus: start, five filters 40'h1..40'h5, pkt_ready=1. Required: packets 0x1_0_4 then 000..01, ..., dest 0001,0101,0011,0111,1100, each one cycle after accept.
REQ-036 Stimulus: 25 ifmap rows, row r = 25'(r+1). Required: rows 0..4 go to PE1..PE5, rows 5..24 go to 1100, all type 00; done is a single pulse after the 25th handshake.
REQ-037 Stimulus: hold pkt_ready=0 for 4 cycles with a packet pending. Required: pkt_out stable, filter_ready/ifmap_ready=0; packet delivered once when ready returns.
REQ-038 Stimulus: assert rst after 3 ifmap packets. Required: all outputs 0 immediately; a new start re-expects filter row 0.
REQ-039 Stimulus: start pulsed during IFMAP, and ifmap_valid=1 during FILTER. Required: both ignored; the packet sequence is unchanged.

Source files
------------

// File: rtl/pe_noc_pkg.sv
// Shared NoC packet definitions for the PE loader, packetizer and depacketizer.
package pe_noc_pkg;

  // PE node addresses
  localparam logic [3:0] PE1_ADDR = 4'b0001;
  localparam logic [3:0] PE2_ADDR = 4'b0101;
  localparam logic [3:0] PE3_ADDR = 4'b0011;
  localparam logic [3:0] PE4_ADDR = 4'b0111;
  localparam logic [3:0] PE5_ADDR = 4'b1100;
  localparam int         NUM_PE   = 5;

  // packet type codes
  localparam logic [1:0] TYPE_IFMAP  = 2'b00;
  localparam logic [1:0] TYPE_FILTER = 2'b01;
  localparam logic [1:0] TYPE_PSUM   = 2'b10;

  // field positions in a 64-bit packet
  localparam int DEST_LSB  = 60;
  localparam int DEST_W    = 4;
  localparam int SRC_LSB   = 56;
  localparam int SRC_W     = 4;
  localparam int TYPE_LSB  = 54;
  localparam int TYPE_W    = 2;
  localparam int PAYLOAD_W = 54;

  // PE index 0..4 -> node address; anything past the end maps to PE5
  function automatic logic [3:0] pe_addr(input logic [2:0] idx);
    case (idx)
      3'd0:    pe_addr = PE1_ADDR;
      3'd1:    pe_addr = PE2_ADDR;
      3'd2:    pe_addr = PE3_ADDR;
      3'd3:    pe_addr = PE4_ADDR;
      default: pe_addr = PE5_ADDR;
    endcase
  endfunction

endpackage

// File: rtl/pkt_out_slot.sv
// One-entry output register with valid/ready handshake toward the NoC.
module pkt_out_slot #(
  parameter int PACKET_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [PACKET_WIDTH-1:0] load_data,
  input  logic                    pkt_ready,
  output logic [PACKET_WIDTH-1:0] pkt_out,
  output logic                    pkt_valid
);

  logic [PACKET_WIDTH-1:0] data_q, data_d;
  logic                    valid_q, valid_d;

  // load wins; otherwise hold until the NoC takes the packet
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q && !pkt_ready;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end
  end

  // slot register, cleared (data included) by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign pkt_out   = data_q;
  assign pkt_valid = valid_q;

endmodule

// File: rtl/pe_loader_tx.sv
// Layer loader: streams five filter rows then NUM_IFMAP_ROWS ifmap rows to the PEs as NoC packets.
module pe_loader_tx
  import pe_noc_pkg::*;
#(
  parameter int         PACKET_WIDTH   = 64,
  parameter int         FILTER_LENGTH  = 40,
  parameter int         IFMAP_LENGTH   = 25,
  parameter int         NUM_IFMAP_ROWS = 25,
  parameter logic [3:0] SRC_ADDR       = 4'b0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [FILTER_LENGTH-1:0] filter_data,
  input  logic                     filter_valid,
  output logic                     filter_ready,
  input  logic [IFMAP_LENGTH-1:0]  ifmap_data,
  input  logic                     ifmap_valid,
  output logic                     ifmap_ready,
  output logic [PACKET_WIDTH-1:0]  pkt_out,
  output logic                     pkt_valid,
  input  logic                     pkt_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W = $clog2(NUM_IFMAP_ROWS + 1);

  typedef enum logic [1:0] {S_IDLE, S_FILTER, S_IFMAP, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    slot_free, f_acc, i_acc, load;
  logic [2:0]              pe_idx;
  logic [PACKET_WIDTH-1:0] pkt_d;

  // state register and row counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // handshakes, next state, counter and completion pulse
  always_comb begin
    slot_free    = !pkt_valid || pkt_ready;
    filter_ready = (state_q == S_FILTER) && slot_free;
    ifmap_ready  = (state_q == S_IFMAP) && slot_free;
    f_acc        = filter_ready && filter_valid;
    i_acc        = ifmap_ready && ifmap_valid;
    load         = f_acc || i_acc;
    state_d      = state_q;
    cnt_d        = cnt_q;
    done         = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_FILTER;
        cnt_d   = '0;
      end
      S_FILTER: if (f_acc) begin
        if (cnt_q == CNT_W'(NUM_PE - 1)) begin
          state_d = S_IFMAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IFMAP: if (i_acc) begin
        if (cnt_q == CNT_W'(NUM_IFMAP_ROWS - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // wait for the final packet to leave before signalling completion
      S_DONE: if (pkt_valid && pkt_ready) begin
        state_d = S_IDLE;
        done    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // packet assembly; rows past PE4 all go to PE5
  always_comb begin
    pe_idx = (cnt_q >= CNT_W'(NUM_PE - 1)) ? 3'(NUM_PE - 1) : cnt_q[2:0];
    pkt_d  = '0;
    pkt_d[DEST_LSB +: DEST_W] = pe_addr(pe_idx);
    pkt_d[SRC_LSB +: SRC_W]   = SRC_ADDR;
    if (state_q == S_FILTER) begin
      pkt_d[TYPE_LSB +: TYPE_W]    = TYPE_FILTER;
      pkt_d[FILTER_LENGTH-1:0]     = filter_data;
    end else begin
      pkt_d[TYPE_LSB +: TYPE_W]    = TYPE_IFMAP;
      pkt_d[IFMAP_LENGTH-1:0]      = ifmap_data;
    end
  end

  assign busy = (state_q != S_IDLE);

  pkt_out_slot #(.PACKET_WIDTH(PACKET_WIDTH)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (pkt_d),
    .pkt_ready (pkt_ready),
    .pkt_out   (pkt_out),
    .pkt_valid (pkt_valid)
  );

endmodule
